// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// The sign is applied once, when the result is registered.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // Two's-complement negate when neg is set (magnitude and result fix-up).
  function automatic logic [XLEN-1:0] cneg_w(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_2w(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   opa_q, opa_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;    // {product hi | remainder, multiplier | dividend->quotient}
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              rs1_sgn, rs2_sgn, rs1_neg, rs2_neg, in_sign, in_div0, in_ovf;
  logic [XLEN-1:0]   mag1, mag2;

  // Decode the request presented on the inputs: signedness, magnitudes, special cases.
  always_comb begin
    rs1_sgn = (funct3 == F_MULH) || (funct3 == F_MULHSU) || (funct3 == F_DIV) || (funct3 == F_REM);
    rs2_sgn = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    rs1_neg = rs1_sgn & rs1_val[XLEN-1];
    rs2_neg = rs2_sgn & rs2_val[XLEN-1];
    mag1    = cneg_w(rs1_val, rs1_neg);
    mag2    = cneg_w(rs2_val, rs2_neg);
    // Remainders take the dividend's sign; products and quotients the XOR.
    in_sign = (funct3[2] && funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
    in_div0 = funct3[2] && (rs2_val == '0);
    in_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
              (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
  end

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, fin_acc, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  // One radix-2 step of each engine plus the sign-corrected final field.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opa_q};
    div_ge   = ~div_diff[XLEN];
    div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    fin_acc  = (state_q == S_MUL) ? mul_nxt : div_nxt;
    // Full-width product is negated before the high/low half is picked.
    prod_fix = cneg_2w(fin_acc, sign_q);
    quo_fix  = cneg_w(fin_acc[XLEN-1:0], sign_q);
    rem_fix  = cneg_w(fin_acc[2*XLEN-1:XLEN], sign_q);
    case (op_q)
      F_MUL:                     fin_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             fin_res = quo_fix;
      default:                   fin_res = rem_fix;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sign_d  = sign_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d   = funct3;
          sign_d = in_sign;
          cnt_d  = '0;
          if (funct3[2]) begin
            opa_d = mag2;
            acc_d = {{XLEN{1'b0}}, mag1};
          end else begin
            opa_d = mag1;
            acc_d = {{XLEN{1'b0}}, mag2};
          end
          if (in_div0) begin
            res_d   = funct3[1] ? rs1_val : '1;
            state_d = S_DONE;
          end else if (in_ovf) begin
            res_d   = funct3[1] ? '0 : rs1_val;
            state_d = S_DONE;
          end else begin
            state_d = funct3[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = fin_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) begin
            res_d   = fin_res;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sign_q  <= 1'b0;
      opa_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed RV32M vectors with literal expectations plus
// a latency/result model checked against the outputs on every cycle.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;
  bit chk_en  = 1'b0;

  mdu_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Model: an accepted op finishes 1 cycle later for special cases, 33 otherwise.
  bit          m_act  = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
      m_pend <= '0;
    end else if (m_act) begin
      if (m_left == 0 || flush) begin
        m_act <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_res <= m_pend;
      end
    end else if (start && !flush) begin
      m_act  <= 1'b1;
      m_pend <= rv32m(funct3, rs1_val, rs2_val);
      if (funct3[2] && (rs2_val == 0 ||
          (!funct3[0] && rs1_val == 32'h8000_0000 && rs2_val == 32'hFFFF_FFFF))) begin
        m_left <= 0;
        m_res  <= rv32m(funct3, rs1_val, rs2_val);
      end else begin
        m_left <= 32;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", {31'b0, busy}, {31'b0, m_act});
      chk("cyc done", {31'b0, done}, {31'b0, (m_act && m_left == 0)});
      chk("cyc result", result, m_res);
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    t_start = cyc;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp, input int lat);
    bit got;
    got = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no done within 40 cycles, expected at latency %0d", name, lat);
    end else begin
      chk({name, " result"}, result, exp);
      chk({name, " latency"}, cyc - t_start, lat);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(posedge clk); #1;
    issue(f, a, b);
    wait_done(name, exp, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, ndone;
    bit got;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 33);
    run_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33);
    run_op("DIV 7/-2",       3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("REM 7/-2",       3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,          33);
    run_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,          32'd14,         33);
    run_op("REMU 100/7",     3'b111, 32'd100,        32'd7,          32'd2,          33);
    run_op("DIVU max/1",     3'b101, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 33);
    run_op("DIVU 5/0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
    run_op("REM 5/0",        3'b110, 32'd5,          32'd0,          32'd5,          1);
    run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1);

    // flush raised for the whole DONE cycle: done and result still appear
    @(posedge clk); #1;
    issue(3'b000, 32'd2, 32'd3);
    t0 = t_start;
    @(posedge clk); #1 start = 1'b0;
    wait_cyc(t0 + 33);
    flush = 1'b1;
    @(negedge clk);
    chk("flush in done: done", {31'b0, done}, 32'd1);
    chk("flush in done: result", result, 32'd6);
    @(posedge clk); #1 flush = 1'b0;
    chk("flush in done: idle after", {31'b0, busy}, 32'd0);

    // flush mid-DIV, then a new MUL straight away
    issue(3'b100, 32'd1000, 32'd3);
    t0 = t_start;
    @(posedge clk); #1 start = 1'b0;
    wait_cyc(t0 + 10);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush mid-div: busy", {31'b0, busy}, 32'd0);
    chk("flush mid-div: done", {31'b0, done}, 32'd0);
    chk("flush mid-div: result kept", result, 32'd6);
    issue(3'b000, 32'd3, 32'd4);
    wait_done("MUL 3*4 after flush", 32'd12, 33);
    chk("MUL after flush: abs cycle", cyc - t0, 32'd44);

    // flush on the final MUL iteration: no result update
    @(posedge clk); #1;
    issue(3'b000, 32'd9, 32'd9);
    t0 = t_start;
    @(posedge clk); #1 start = 1'b0;
    wait_cyc(t0 + 32);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush last iter: busy", {31'b0, busy}, 32'd0);
    chk("flush last iter: done", {31'b0, done}, 32'd0);
    chk("flush last iter: result kept", result, 32'd12);

    // start held high throughout: exactly one done
    @(posedge clk); #1;
    issue(3'b000, 32'd5, 32'd6);
    ndone = 0;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      funct3  = 3'b101;
      rs1_val = $urandom;
      rs2_val = $urandom;
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        ndone++;
        chk("held start: result", result, 32'd30);
        chk("held start: latency", cyc - t_start, 32'd33);
      end
    end
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("held start: done count", ndone, 32'd1);

    // flush with start in IDLE drops the request
    @(posedge clk); #1;
    issue(3'b000, 32'd2, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    chk("idle flush drops start", {31'b0, busy}, 32'd0);

    // asynchronous reset mid-MUL
    @(posedge clk); #1;
    issue(3'b000, 32'h1234, 32'h5678);
    t0 = t_start;
    @(posedge clk); #1 start = 1'b0;
    wait_cyc(t0 + 15);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid-op reset busy", {31'b0, busy}, 32'd0);
    chk("mid-op reset done", {31'b0, done}, 32'd0);
    chk("mid-op reset result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op("MUL after reset", 3'b000, 32'd11, 32'd13, 32'd143, 33);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
